// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential 16-bit restoring divider.
package seq_div_pkg;

  localparam int               DIV_W         = 16;
  localparam logic [3:0]       ITER_LAST     = 4'd15;
  localparam logic [DIV_W-1:0] DIV0_QUOTIENT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

endpackage

// File: rtl/Subtractor_16bit.sv
// Ripple-borrow 16-bit subtractor: Dfinal = {borrow, a - b}.
module Subtractor_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [16:0] Dfinal
);

  always_comb begin : ripple
    logic borrow;
    borrow = 1'b0;
    Dfinal = '0;
    for (int i = 0; i < 16; i++) begin
      Dfinal[i] = a[i] ^ b[i] ^ borrow;
      borrow    = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow);
    end
    Dfinal[16] = borrow;
  end

endmodule

// File: rtl/seq_divider_16bit.sv
// Multi-cycle unsigned 16-bit restoring divider: one trial subtraction per
// cycle through a shared ripple-borrow subtractor, start/ready/done handshake.
module seq_divider_16bit
  import seq_div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             div_by_zero
);

  state_t           state, state_nxt;
  logic [DIV_W-1:0] r_q, q_q, d_q;
  logic [3:0]       count;

  logic [DIV_W-1:0] trial;
  logic             carry;
  logic [DIV_W:0]   diff;
  logic             accept;
  logic [DIV_W-1:0] r_nxt, q_nxt;

  // Shift the next dividend bit into the partial remainder and try D.
  assign trial = {r_q[DIV_W-2:0], q_q[DIV_W-1]};
  assign carry = r_q[DIV_W-1];

  Subtractor_16bit u_sub (
    .a      (trial),
    .b      (d_q),
    .Dfinal (diff)
  );

  // A shifted-out MSB means the true trial is >= 2^16 > D, so the subtraction
  // always succeeds and the wrapped low 16 bits are the exact remainder.
  assign accept = carry | ~diff[DIV_W];
  assign r_nxt  = accept ? diff[DIV_W-1:0] : trial;
  assign q_nxt  = {q_q[DIV_W-2:0], accept};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (divisor == '0) ? FIN : CALC;
      CALC:    if (count == ITER_LAST) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decode the state only, so start never reaches them
  // combinationally.
  always_comb begin
    ready = (state == IDLE);
    done  = (state == FIN);
  end

  // Results are written on the edge entering FIN and then held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            d_q   <= divisor;
            q_q   <= dividend;
            r_q   <= '0;
            count <= '0;
            if (divisor == '0) begin
              quotient    <= DIV0_QUOTIENT;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          r_q   <= r_nxt;
          q_q   <= q_nxt;
          count <= count + 4'd1;
          if (count == ITER_LAST) begin
            quotient    <= q_nxt;
            remainder   <= r_nxt;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_16bit.sv
// Self-checking bench for seq_divider_16bit: arithmetic reference model with a
// per-cycle compare, plus directed vectors with hand-computed results.
module tb_seq_divider_16bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend, divisor;
  logic        ready, done, div_by_zero;
  logic [15:0] quotient, remainder;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_divider_16bit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the handshake by latency and computes results
  // with plain / and %.
  bit          m_valid = 1'b0;
  bit          m_ready, m_done, m_z;
  logic [15:0] m_q, m_r, p_a, p_b;
  int          m_left;

  function automatic void finish_op();
    m_done = 1'b1;
    if (p_b == 16'd0) begin
      m_q = 16'hFFFF; m_r = p_a; m_z = 1'b1;
    end else begin
      m_q = p_a / p_b; m_r = p_a % p_b; m_z = 1'b0;
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1; m_ready = 1'b1; m_done = 1'b0;
      m_q = '0; m_r = '0; m_z = 1'b0; m_left = 0;
    end else if (m_valid) begin
      if (m_done) begin
        m_done = 1'b0; m_ready = 1'b1;
      end else if (!m_ready) begin
        m_left--;
        if (m_left == 0) finish_op();
      end else if (start) begin
        p_a = dividend; p_b = divisor; m_ready = 1'b0;
        if (divisor == 16'd0) finish_op();
        else m_left = 16;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("ready", ready, m_ready);
      check("done", done, m_done);
      if (m_ready || m_done) begin
        check("quotient", quotient, m_q);
        check("remainder", remainder, m_r);
        check("div_by_zero", div_by_zero, m_z);
      end
    end
  end

  // Issue one division from IDLE and wait (bounded) for done.
  task automatic do_div(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er,
                        input logic ez, input int elat);
    int lat;
    bit seen;
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = 16'($urandom); divisor = 16'($urandom);
    lat = 1; seen = 1'b0;
    while (!seen && lat <= 40) begin
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    check("latency", lat, elat);
    check("lit_quotient", quotient, eq);
    check("lit_remainder", remainder, er);
    check("lit_div0", div_by_zero, ez);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone, dcyc, nrdy;
    logic [15:0] a, b;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_quotient", quotient, 16'd0);
    check("rst_remainder", remainder, 16'd0);
    check("rst_div0", div_by_zero, 1'b0);
    rst = 1'b0;

    // 100 / 7 with explicit ready-low window (cycles 1..17)
    dividend = 16'd100; divisor = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; dcyc = 0; nrdy = 0;
    for (int c = 1; c <= 17; c++) begin
      if (done) begin ndone++; dcyc = c; end
      if (!ready) nrdy++;
      @(posedge clk); #1;
    end
    check("100/7 done count", ndone, 1);
    check("100/7 done cycle", dcyc, 17);
    check("100/7 ready low cycles", nrdy, 17);
    check("100/7 ready back", ready, 1'b1);
    check("100/7 quotient", quotient, 16'd14);
    check("100/7 remainder", remainder, 16'd2);

    do_div(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17);
    do_div(16'h0005, 16'h0009, 16'h0000, 16'h0005, 1'b0, 17);
    do_div(16'hFFFE, 16'h8001, 16'h0001, 16'h7FFD, 1'b0, 17);
    do_div(16'd5,    16'd0,    16'hFFFF, 16'd5,    1'b1, 1);
    do_div(16'd9,    16'd3,    16'd3,    16'd0,    1'b0, 17);
    do_div(16'hFFFF, 16'hFFFF, 16'd1,    16'd0,    1'b0, 17);
    do_div(16'h0000, 16'h0001, 16'd0,    16'd0,    1'b0, 17);
    do_div(16'h8000, 16'h0003, 16'h2AAA, 16'h0002, 1'b0, 17);

    // Starts at cycles 3 and 16 must be ignored
    dividend = 16'd100; divisor = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; dcyc = 0;
    for (int c = 1; c <= 17; c++) begin
      start    = (c == 3 || c == 16);
      dividend = 16'($urandom);
      divisor  = (c == 3) ? 16'd0 : 16'($urandom);
      if (done) begin ndone++; dcyc = c; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("ignored-start done count", ndone, 1);
    check("ignored-start done cycle", dcyc, 17);
    repeat (5) begin
      check("held quotient", quotient, 16'd14);
      check("held remainder", remainder, 16'd2);
      @(posedge clk); #1;
    end

    // Reset mid-CALC aborts without a done pulse
    dividend = 16'd100; divisor = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort ready", ready, 1'b1);
    check("abort done", done, 1'b0);
    check("abort quotient", quotient, 16'd0);
    check("abort remainder", remainder, 16'd0);
    check("abort div0", div_by_zero, 1'b0);
    ndone = 0;
    repeat (20) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    check("abort no done", ndone, 0);
    do_div(16'd20, 16'd6, 16'd3, 16'd2, 1'b0, 17);

    // Random sweep against plain arithmetic
    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'($urandom_range(1, 20));
        1:       b = 16'($urandom) | 16'h8000;
        2:       b = (i % 25 == 0) ? 16'd0 : 16'($urandom_range(1, 255));
        default: b = 16'($urandom);
      endcase
      if (b == 16'd0) do_div(a, b, 16'hFFFF, a, 1'b1, 1);
      else            do_div(a, b, a / b, a % b, 1'b0, 17);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
